// File: rtl/io_vpw_bias_ctrl.sv
// io_vpw_bias_ctrl: VPW p-well body-bias sequencer.
// Enables the generator, ramps the DAC code one LSB per dwell, then confirms regulation.
module io_vpw_bias_ctrl #(
    parameter int CODE_W         = 6,
    parameter int STEP_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int OK_FILT        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CODE_W-1:0] req_code,
    input  logic              req_off,
    input  logic              err_clr,
    input  logic              gen_ok,
    output logic              bias_en,
    output logic [CODE_W-1:0] bias_code,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int SW = $clog2(STEP_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(OK_FILT + 1);

    typedef enum logic [2:0] {IDLE, ENABLE, RAMP, CHECK, OFF, DONE, ERR} state_t;

    state_t            state, state_n;
    logic [1:0]        ok_sync;
    logic              gen_ok_s, step, en_n;
    logic [CODE_W-1:0] target, target_n, code_n;
    logic [SW-1:0]     cnt, cnt_n;
    logic [TW-1:0]     tmo, tmo_n;
    logic [FW-1:0]     filt, filt_n;

    assign gen_ok_s = ok_sync[1];
    assign step     = cnt == SW'(STEP_CYCLES - 1);

    always_comb begin
        state_n  = state;
        target_n = target;
        code_n   = bias_code;
        en_n     = bias_en;
        cnt_n    = step ? '0 : cnt + 1'b1;
        tmo_n    = tmo;
        filt_n   = filt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (req_valid) begin
                    target_n = req_code;
                    tmo_n    = '0;
                    filt_n   = '0;
                    en_n     = bias_en | ~req_off;
                    state_n  = req_off ? OFF : !bias_en ? ENABLE : bias_code != req_code ? RAMP : CHECK;
                end
            end
            ENABLE: if (step) state_n = bias_code == target ? CHECK : RAMP;
            RAMP: if (step) begin
                code_n  = bias_code < target ? bias_code + 1'b1 : bias_code - 1'b1;
                state_n = code_n == target ? CHECK : RAMP;
            end
            CHECK: begin
                filt_n = gen_ok_s ? filt + 1'b1 : '0;
                tmo_n  = tmo + 1'b1;
                if (filt == FW'(OK_FILT)) state_n = DONE;
                else if (tmo == TW'(TIMEOUT_CYCLES)) begin
                    state_n = ERR;
                    code_n  = '0;
                    en_n    = 1'b0;
                end
            end
            OFF: if (step) begin
                code_n  = bias_code != '0 ? bias_code - 1'b1 : '0;
                en_n    = bias_code != '0;
                state_n = bias_code != '0 ? OFF : DONE;
            end
            DONE:    state_n = IDLE;
            ERR:     state_n = err_clr ? IDLE : ERR;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) ok_sync <= '0;
        else ok_sync <= {ok_sync[0], gen_ok};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= IDLE;
            target    <= '0;
            bias_code <= '0;
            bias_en   <= 1'b0;
            cnt       <= '0;
            tmo       <= '0;
            filt      <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            bias_code <= code_n;
            bias_en   <= en_n;
            cnt       <= cnt_n;
            tmo       <= tmo_n;
            filt      <= filt_n;
            req_ready <= state_n == IDLE;
            busy      <= state_n inside {ENABLE, RAMP, CHECK, OFF};
            done      <= state_n == DONE;
            err       <= state_n == ERR;
        end
endmodule

// File: tb/tb_io_vpw_bias_ctrl.sv
// tb_io_vpw_bias_ctrl: directed cycle-accurate checks of the bias sequencer.
// Cycle 0 is the accept cycle; outputs are sampled 1 time unit after each rising edge.
module tb_io_vpw_bias_ctrl;
    localparam int CW = 6;

    logic          clk = 0, rst = 1, req_valid = 0, req_off = 0, err_clr = 0, gen_ok = 0;
    logic [CW-1:0] req_code = '0;
    logic          req_ready, bias_en, busy, done, err;
    logic [CW-1:0] bias_code;
    int            checks = 0, errors = 0, cyc = 0;

    always #5 clk = ~clk;

    io_vpw_bias_ctrl #(.CODE_W(CW), .STEP_CYCLES(4), .TIMEOUT_CYCLES(32), .OK_FILT(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_code(req_code), .req_off(req_off), .err_clr(err_clr), .gen_ok(gen_ok),
        .bias_en(bias_en), .bias_code(bias_code), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv(input int n);
        while (cyc < n) tick();
    endtask

    task automatic req(input int code, input bit off);
        req_code  = CW'(code);
        req_off   = off;
        req_valid = 1;
        cyc       = 0;
        tick();
        req_valid = 0;
        req_off   = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", bias_en, 0);
        chk("rst_code", bias_code, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 0;
        gen_ok = 1;
        repeat (3) tick();

        req(3, 0);
        chk("cold_en", bias_en, 1);
        chk("cold_busy", busy, 1);
        chk("cold_code0", bias_code, 0);
        adv(8);  chk("cold_c8", bias_code, 0);
        adv(9);  chk("cold_c9", bias_code, 1);
        adv(13); chk("cold_c13", bias_code, 2);
        adv(17); chk("cold_c17", bias_code, 3);
        adv(21); chk("cold_done21", done, 0);
        adv(22); chk("cold_done22", done, 1); chk("cold_rdy22", req_ready, 0);
        adv(23); chk("cold_done23", done, 0); chk("cold_rdy23", req_ready, 1);

        req(5, 0);
        adv(9);  chk("up_c9", bias_code, 5);
        adv(15); chk("up_rdy", req_ready, 1);
        req(2, 0);
        chk("dn_en1", bias_en, 1);
        chk("dn_c1", bias_code, 5);
        adv(4);  chk("dn_c4", bias_code, 5);
        adv(5);  chk("dn_c5", bias_code, 4);
        adv(9);  chk("dn_c9", bias_code, 3);
        adv(13); chk("dn_c13", bias_code, 2); chk("dn_en13", bias_en, 1);
        adv(17); chk("dn_done17", done, 0);
        adv(18); chk("dn_done18", done, 1);
        adv(19); chk("dn_rdy", req_ready, 1);

        req(3, 0);
        adv(5);  chk("gl_c5", bias_code, 3);
        adv(6);  gen_ok = 0;
        tick();  gen_ok = 1;
        adv(10); chk("gl_done10", done, 0);
        adv(13); chk("gl_done13", done, 0);
        adv(14); chk("gl_done14", done, 1); chk("gl_err", err, 0);
        adv(15);

        gen_ok = 0;
        req(7, 0);
        adv(17); chk("to_c17", bias_code, 7);
        adv(49); chk("to_err49", err, 0); chk("to_en49", bias_en, 1);
        adv(50);
        chk("to_err50", err, 1);
        chk("to_en50", bias_en, 0);
        chk("to_code50", bias_code, 0);
        chk("to_rdy50", req_ready, 0);
        req_code = 1;
        req_valid = 1;
        adv(54);
        chk("to_hold_err", err, 1);
        chk("to_hold_en", bias_en, 0);
        chk("to_hold_rdy", req_ready, 0);
        req_valid = 0;
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("clr_err", err, 0);
        chk("clr_rdy", req_ready, 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("clr_idle_busy", busy, 0);
        chk("clr_idle_rdy", req_ready, 1);

        gen_ok = 1;
        repeat (3) tick();
        req(2, 0);
        adv(13); chk("pre_c13", bias_code, 2);
        adv(19); chk("pre_rdy", req_ready, 1);
        req(9, 1);
        chk("off_busy", busy, 1);
        adv(5);  chk("off_c5", bias_code, 1);
        adv(9);  chk("off_c9", bias_code, 0); chk("off_en9", bias_en, 1);
        adv(12); chk("off_en12", bias_en, 1); chk("off_done12", done, 0);
        adv(13); chk("off_en13", bias_en, 0); chk("off_done13", done, 1);
        adv(14); chk("off_done14", done, 0); chk("off_rdy14", req_ready, 1);

        req(5, 0);
        adv(21); chk("rr_c21", bias_code, 4);
        adv(22);
        rst = 1;
        #1;
        chk("rr_en", bias_en, 0);
        chk("rr_code", bias_code, 0);
        chk("rr_busy", busy, 0);
        tick();
        tick();
        rst = 0;
        tick();
        chk("rr_rdy", req_ready, 1);
        for (int i = 0; i < 6; i++) begin
            chk("rr_nodone", done, 0);
            chk("rr_noerr", err, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_vpw_bias_ctrl.md
# io_vpw_bias_ctrl

Digital sequencer that drives the body-bias generator feeding the VPW p-well bias pad of the EG1D80V IO ring. It accepts a target bias code from the chip control bus and enables the generator. It ramps the code one LSB at a time with a programmable dwell, then confirms regulation through the generator's status flag before reporting done. It also ramps bias down and disables the generator on request, and forces a safe state on timeout.

## Interface
Parameters:
- CODE_W, 6, width of bias code
- STEP_CYCLES, 16, dwell cycles per code step and after enable (≥2)
- TIMEOUT_CYCLES, 1024, max cycles in CHECK waiting for generator regulation
- OK_FILT, 4, consecutive synchronized gen_ok highs required

Ports:
- clk  in  1  single block clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe
- req_ready  out  1  block can accept a request
- req_code  in  CODE_W  target bias code
- req_off  in  1  request is power-down (req_code ignored)
- err_clr  in  1  clears sticky error
- gen_ok  in  1  generator regulation flag (asynchronous to clk)
- bias_en  out  1  generator enable
- bias_code  out  CODE_W  code to generator DAC
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout error

## Operation
- Reset values: bias_en=0, bias_code=0, req_ready=1, busy=0, done=0, err=0; FSM=IDLE; all counters 0.
- gen_ok passes through a 2-FF synchronizer; only gen_ok_s is used.
- States: IDLE, ENABLE, RAMP, CHECK, OFF, DONE, ERR.
- IDLE: req_ready=1. A request is accepted on req_valid & req_ready. target is latched. busy=1 from the next cycle. Transitions on accept:
  - req_off=1 → OFF.
  - bias_en=0 → ENABLE.
  - bias_code≠target → RAMP.
  - otherwise → CHECK.
- ENABLE: bias_en=1. Count STEP_CYCLES cycles, then go to RAMP (or CHECK if bias_code==target).
- RAMP: every STEP_CYCLES cycles, bias_code moves ±1 toward target. The code never overshoots. Go to CHECK the cycle bias_code==target.
- CHECK: the filter counter increments while gen_ok_s=1 and clears to 0 when gen_ok_s=0.
  - Counter reaches OK_FILT → DONE.
  - Timeout counter reaches TIMEOUT_CYCLES first → ERR.
- OFF: ramp bias_code toward 0 at STEP_CYCLES per step. On reaching 0, wait one more STEP_CYCLES, deassert bias_en, → DONE. No CHECK is done on power-down.
- DONE: done=1 for exactly one cycle, then → IDLE.
- ERR: bias_en=0 and bias_code=0 in the same cycle the state is entered. err=1 and stays set. req_ready=0.
  - err_clr → IDLE with err=0 the next cycle.
  - err_clr outside ERR has no effect.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- Codes are unsigned; the comparison uses the full CODE_W width. There is no wrap; code range is 0..2^CODE_W−1.
- Reset asserted mid-sequence drops bias_en and bias_code to 0 immediately. The block ends in IDLE with no done pulse.

## Timing
- Accept at cycle 0: bias_en=1 and busy=1 at cycle 1.
- From cold (bias_en=0, code 0), code k first appears at cycle 1+STEP_CYCLES·(k+1).
- With gen_ok stable high, done pulses OK_FILT+1 cycles after bias_code reaches target.
- gen_ok edge to gen_ok_s: 2 cycles.
- req_ready returns to 1 the cycle after done.
- Timeout: err rises TIMEOUT_CYCLES+1 cycles after CHECK entry if the filter never completes.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- STEP_CYCLES=4, cold request code 3, gen_ok=1 → bias_en at cycle 1; code 1/2/3 at cycles 9/13/17; done pulse at cycle 22; req_ready=1 at 23.
- Running at code 5, request code 2 → code steps 4,3,2 every STEP_CYCLES with no ENABLE dwell; bias_en stays 1; done after filter.
- Request code 7 with gen_ok held 0, TIMEOUT_CYCLES=32 → err=1 and bias_en=0, bias_code=0 at CHECK entry+33. Further req_valid is ignored until err_clr; then req_ready=1.
- gen_ok glitches low for 1 cycle after 3 high samples in CHECK → filter restarts; done is delayed by 4 more cycles; no err.
- From code 2, req_off → code 1, 0 at STEP_CYCLES spacing; bias_en falls STEP_CYCLES later; single done pulse.
- rst asserted while in RAMP at code 4 → same-cycle bias_en=0, bias_code=0, busy=0; after release, req_ready=1 and no done or err.
